// File: rtl/img_pkg.sv
// Shared definitions for the RGB565 image stream source and capture blocks:
// pixel field layout, default geometry and the capture FSM encoding.
package img_pkg;

    localparam int RGB565_R_MSB = 15;
    localparam int RGB565_R_LSB = 11;
    localparam int RGB565_G_MSB = 10;
    localparam int RGB565_G_LSB = 5;
    localparam int RGB565_B_MSB = 4;
    localparam int RGB565_B_LSB = 0;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    localparam int IMG_ACTIVE_IW = 640;
    localparam int IMG_ACTIVE_IH = 480;

    localparam logic [1:0] ST_SYNC   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

endpackage

// File: rtl/img_cap_rgb565_if.sv
// vs/de/data video stream; the source drives it (master), the capture block samples it (slave).
interface img_cap_rgb565_if;
    logic        vs;
    logic        de;
    logic [15:0] data;

    modport master (output vs, de, data);
    modport slave  (input  vs, de, data);
endinterface

// File: rtl/img_sync_edge.sv
// One-stage register of vs/de plus rise/fall pulses measured against a second delayed copy.
module img_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic vs,
    input  logic de,
    output logic vs_d,
    output logic de_d,
    output logic vs_rise,
    output logic vs_fall,
    output logic de_rise,
    output logic de_fall
);
    logic vs_q;
    logic de_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d <= 1'b0;
            de_d <= 1'b0;
            vs_q <= 1'b0;
            de_q <= 1'b0;
        end else begin
            vs_d <= vs;
            de_d <= de;
            vs_q <= vs_d;
            de_q <= de_d;
        end
    end

    assign vs_rise = vs_d & ~vs_q;
    assign vs_fall = ~vs_d & vs_q;
    assign de_rise = de_d & ~de_q;
    assign de_fall = ~de_d & de_q;
endmodule

// File: rtl/img_cap_rgb565.sv
// Captures an RGB565 vs/de stream into a linear frame-buffer write port and
// reports per-frame geometry errors, checksum and frame count.
//
// state  | meaning
// SYNC   | after reset, discard input until the first vs falling edge
// WAIT   | frame scratch cleared, waiting for the first active pixel
// ACTIVE | inside the frame body, counting and writing pixels
module img_cap_rgb565
    import img_pkg::*;
#(
    parameter int ACTIVE_IW = IMG_ACTIVE_IW,
    parameter int ACTIVE_IH = IMG_ACTIVE_IH,
    parameter int ADDR_W    = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    img_cap_rgb565_if.slave   vid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              frame_done,
    output logic              frame_err,
    output logic              line_len_err,
    output logic              line_cnt_err,
    output logic [31:0]       checksum,
    output logic [15:0]       frame_cnt
);
    localparam logic [31:0]       IW   = 32'(ACTIVE_IW);
    localparam logic [31:0]       IH   = 32'(ACTIVE_IH);
    localparam logic [ADDR_W-1:0] IW_A = ADDR_W'(ACTIVE_IW);

    logic        vs_d, de_d, vs_rise, vs_fall, de_rise, de_fall;
    logic [15:0] data_d;

    img_sync_edge u_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .vs      (vid.vs),
        .de      (vid.de),
        .vs_d    (vs_d),
        .de_d    (de_d),
        .vs_rise (vs_rise),
        .vs_fall (vs_fall),
        .de_rise (de_rise),
        .de_fall (de_fall)
    );

    logic unused_edges;
    assign unused_edges = vs_rise | de_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_d <= '0;
        else        data_d <= vid.data;
    end

    logic [1:0]        state;
    logic [15:0]       x, y;
    logic [31:0]       acc;
    logic              len_bad;
    logic [ADDR_W-1:0] addr, line_base;

    logic        pix_valid, in_range, line_end, len_end, cnt_end;
    logic [15:0] x_inc, y_inc, y_end;

    assign pix_valid = de_d & vs_d;
    assign in_range  = ({16'd0, x} < IW) && ({16'd0, y} < IH);
    assign x_inc     = (x == 16'hFFFF) ? x : x + 16'd1;
    assign y_inc     = (y == 16'hFFFF) ? y : y + 16'd1;
    assign line_end  = de_fall && (state == ST_ACTIVE);
    // A line closing in the same cycle as the frame is counted before the frame check.
    assign y_end     = line_end ? y_inc : y;
    assign len_end   = len_bad | (line_end && ({16'd0, x} != IW));
    assign cnt_end   = {16'd0, y_end} != IH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_SYNC;
            x            <= '0;
            y            <= '0;
            acc          <= '0;
            len_bad      <= 1'b0;
            addr         <= '0;
            line_base    <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
            line_len_err <= 1'b0;
            line_cnt_err <= 1'b0;
            checksum     <= '0;
            frame_cnt    <= '0;
        end else begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            if (vs_fall) begin
                if (state != ST_SYNC) begin
                    frame_done   <= 1'b1;
                    checksum     <= acc;
                    line_len_err <= len_end;
                    line_cnt_err <= cnt_end;
                    frame_err    <= len_end | cnt_end;
                    frame_cnt    <= frame_cnt + 16'd1;
                end
                state     <= ST_WAIT;
                x         <= '0;
                y         <= '0;
                acc       <= '0;
                // vs_d is low here, so any de_d already belongs to the next frame's sync interval.
                len_bad   <= de_d;
                addr      <= '0;
                line_base <= '0;
            end else if (state != ST_SYNC) begin
                if (pix_valid) begin
                    state <= ST_ACTIVE;
                    x     <= x_inc;
                    acc   <= acc + {16'd0, data_d};
                    if (in_range) begin
                        wr_en   <= 1'b1;
                        wr_addr <= addr;
                        wr_data <= data_d;
                        addr    <= addr + ADDR_W'(1);
                    end
                end else if (de_d) begin
                    len_bad <= 1'b1;
                end else if (line_end) begin
                    if ({16'd0, x} != IW) len_bad <= 1'b1;
                    y <= y_inc;
                    x <= '0;
                    if ({16'd0, y} + 32'd1 < IH) begin
                        line_base <= line_base + IW_A;
                        addr      <= line_base + IW_A;
                    end
                end
            end
        end
    end
endmodule
